// File: rtl/dbg_pkg.sv
// Shared definitions for the serial debug bridge: opcode bytes, ACK byte and FSM states.
package dbg_pkg;

  localparam logic [7:0] OP_HOLD   = 8'h48;
  localparam logic [7:0] OP_GO     = 8'h47;
  localparam logic [7:0] OP_WR     = 8'h57;
  localparam logic [7:0] OP_RD     = 8'h52;
  localparam logic [7:0] OP_WR_INC = 8'h77;
  localparam logic [7:0] OP_RD_INC = 8'h72;
  localparam logic [7:0] ACK_BYTE  = 8'h06;

  localparam int LAT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_TX_H,
    ST_TX_L,
    ST_ACK
  } state_t;

  // States in which a host byte may be consumed.
  function automatic logic accepts_rx(input state_t s);
    return (s == ST_IDLE) || (s == ST_ADDR_H) || (s == ST_ADDR_L) ||
           (s == ST_DATA_H) || (s == ST_DATA_L);
  endfunction

endpackage

// File: rtl/dbg_bridge.sv
// UART-to-bus debug/boot bridge: parses host commands and masters 16-bit bus reads/writes.
// Optional DBG_BRIDGE_ACK_EN: send ACK_BYTE after every completed write.
module dbg_bridge
  import dbg_pkg::*;
#(
  parameter bit          HOLD_ON_RESET = 1'b1,
  parameter int          READ_LAT      = 1,
  parameter logic [15:0] NOHOLD_RDATA  = 16'hDEAD
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic [15:0] o_bus_addr,
  output logic [15:0] o_bus_wdata,
  output logic        o_bus_we,
  input  logic [15:0] i_bus_rdata,
  output logic        o_cpu_hold
);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT);

  state_t           state_reg, state_next;
  logic [15:0]      addr_reg, addr_next;
  logic [15:0]      data_reg, data_next;
  logic [15:0]      rdata_reg, rdata_next;
  logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
  logic             is_wr_reg, is_wr_next;
  logic             hold_reg, hold_next;
  logic             rx_fire, tx_fire;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      rdata_reg   <= '0;
      lat_cnt_reg <= '0;
      is_wr_reg   <= 1'b0;
      hold_reg    <= HOLD_ON_RESET;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      rdata_reg   <= rdata_next;
      lat_cnt_reg <= lat_cnt_next;
      is_wr_reg   <= is_wr_next;
      hold_reg    <= hold_next;
    end
  end

  always_comb begin
    // Outputs decode from registered state so a reset drops them immediately.
    o_rx_ready  = accepts_rx(state_reg);
    o_bus_addr  = addr_reg;
    o_bus_wdata = data_reg;
    o_bus_we    = (state_reg == ST_BUS_WR) && hold_reg;
    o_cpu_hold  = hold_reg;
    o_tx_valid  = 1'b0;
    o_tx_data   = 8'h00;
    case (state_reg)
      ST_TX_H: begin o_tx_valid = 1'b1; o_tx_data = rdata_reg[15:8]; end
      ST_TX_L: begin o_tx_valid = 1'b1; o_tx_data = rdata_reg[7:0];  end
      ST_ACK:  begin o_tx_valid = 1'b1; o_tx_data = ACK_BYTE;        end
      default: ;
    endcase
    rx_fire = i_rx_valid && o_rx_ready;
    tx_fire = o_tx_valid && i_tx_ready;

    state_next   = state_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    rdata_next   = rdata_reg;
    lat_cnt_next = lat_cnt_reg;
    is_wr_next   = is_wr_reg;
    hold_next    = hold_reg;

    case (state_reg)
      ST_IDLE: begin
        if (rx_fire) begin
          case (i_rx_data)
            OP_HOLD:   hold_next = 1'b1;
            OP_GO:     hold_next = 1'b0;
            OP_WR:     begin is_wr_next = 1'b1; state_next = ST_ADDR_H; end
            OP_RD:     begin is_wr_next = 1'b0; state_next = ST_ADDR_H; end
            OP_WR_INC: state_next = ST_DATA_H;
            OP_RD_INC: begin lat_cnt_next = '0; state_next = ST_BUS_RD; end
            default:   ;
          endcase
        end
      end
      ST_ADDR_H: begin
        if (rx_fire) begin
          addr_next  = {addr_reg[7:0], i_rx_data};
          state_next = ST_ADDR_L;
        end
      end
      ST_ADDR_L: begin
        if (rx_fire) begin
          addr_next    = {addr_reg[7:0], i_rx_data};
          lat_cnt_next = '0;
          state_next   = is_wr_reg ? ST_DATA_H : ST_BUS_RD;
        end
      end
      ST_DATA_H: begin
        if (rx_fire) begin
          data_next  = {data_reg[7:0], i_rx_data};
          state_next = ST_DATA_L;
        end
      end
      ST_DATA_L: begin
        if (rx_fire) begin
          data_next  = {data_reg[7:0], i_rx_data};
          state_next = ST_BUS_WR;
        end
      end
      ST_BUS_WR: begin
        addr_next = addr_reg + 16'd1;
`ifdef DBG_BRIDGE_ACK_EN
        state_next = ST_ACK;
`else
        state_next = ST_IDLE;
`endif
      end
      ST_BUS_RD: begin
        // Address is held from entry; data is sampled READ_LAT cycles after it is registered by the RAM.
        if (lat_cnt_reg == LAT_LAST) begin
          rdata_next = hold_reg ? i_bus_rdata : NOHOLD_RDATA;
          addr_next  = addr_reg + 16'd1;
          state_next = ST_TX_H;
        end else begin
          lat_cnt_next = lat_cnt_reg + 1'b1;
        end
      end
      ST_TX_H: if (tx_fire) state_next = ST_TX_L;
      ST_TX_L: if (tx_fire) state_next = ST_IDLE;
      ST_ACK:  if (tx_fire) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbg_bridge.sv
// Randomised self-checking bench for dbg_bridge against a command-level reference model.
module tb_dbg_bridge;

`ifdef DBG_BRIDGE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic [15:0] bus_rdata = 16'h0000;
  logic        cpu_hold;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dbg_bridge dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rx_ready (rx_ready),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .o_bus_addr (bus_addr),
    .o_bus_wdata(bus_wdata),
    .o_bus_we   (bus_we),
    .i_bus_rdata(bus_rdata),
    .o_cpu_hold (cpu_hold)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Synchronous SoC RAM: one-cycle registered read.
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus_we) ram[bus_addr] <= bus_wdata;
    bus_rdata <= ram[bus_addr];
  end

  // Transmitter ready: optional forced stall, otherwise random or always ready.
  int tx_stall = 0;
  bit tx_rand  = 1'b0;
  always @(posedge clk) begin
    #2;
    if (tx_stall > 0) begin
      tx_ready = 1'b0;
      tx_stall--;
    end else begin
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: collect bus writes and tx bytes, and check tx stays stable while stalled.
  logic [31:0] wr_q[$];
  logic [7:0]  tx_q[$];
  bit          tx_pend = 1'b0;
  logic [7:0]  tx_pend_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      tx_pend = 1'b0;
    end else begin
      if (tx_pend) begin
        check("tx_stall_valid", 32'(tx_valid), 32'd1);
        check("tx_stall_data", 32'(tx_data), 32'(tx_pend_data));
      end
      if (bus_we) wr_q.push_back({bus_addr, bus_wdata});
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      tx_pend      = tx_valid && !tx_ready;
      tx_pend_data = tx_data;
    end
  end

  // Reference model state.
  logic [15:0] m_mem [int];
  logic [15:0] m_addr = 16'h0000;
  bit          m_hold = 1'b1;

  function automatic logic [15:0] m_rd(input logic [15:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : init_val(a);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d);
    logic [7:0]  bytes[$];
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] v;
    bit          busy_rx = 1'b0;
    int          n = 0;
    bytes.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      bytes.push_back(a[15:8]);
      bytes.push_back(a[7:0]);
    end
    if (op == 8'h57 || op == 8'h77) begin
      bytes.push_back(d[15:8]);
      bytes.push_back(d[7:0]);
    end
    wr_q.delete();
    tx_q.delete();
    foreach (bytes[i]) send_byte(bytes[i]);

    case (op)
      8'h48: m_hold = 1'b1;
      8'h47: m_hold = 1'b0;
      8'h57, 8'h77: begin
        if (op == 8'h57) m_addr = a;
        if (m_hold) begin
          exp_wr.push_back({m_addr, d});
          m_mem[int'(m_addr)] = d;
        end
        m_addr = m_addr + 16'd1;
        if (ACK_EN) exp_tx.push_back(8'h06);
      end
      8'h52, 8'h72: begin
        if (op == 8'h52) m_addr = a;
        v = m_hold ? m_rd(m_addr) : 16'hDEAD;
        exp_tx.push_back(v[15:8]);
        exp_tx.push_back(v[7:0]);
        m_addr = m_addr + 16'd1;
      end
      default: ;
    endcase

    while (tx_q.size() < exp_tx.size() && n < 300) begin
      @(negedge clk);
      #1;
      if (rx_ready && tx_q.size() < exp_tx.size()) busy_rx = 1'b1;
      n++;
    end
    repeat (4) @(negedge clk);
    #1;
    check("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i]) if (i < wr_q.size()) check("wr_addr_data", wr_q[i], exp_wr[i]);
    check("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) if (i < tx_q.size()) check("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
    check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    if (exp_tx.size() == 2) check("rx_ready_busy", 32'(busy_rx), 32'd0);
    $display("[TB] cmd %h addr=%h data=%h hold=%0d writes=%0d tx_bytes=%0d",
             op, a, d, m_hold, wr_q.size(), tx_q.size());
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},       32'(bus_we),    32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid),  32'd0);
    check({tag, "_hold"},     32'(cpu_hold),  32'd1);
    check({tag, "_rx_ready"}, 32'(rx_ready),  32'd1);
  endtask

  logic [7:0] ops [0:5];

  initial begin
    logic [7:0]  op;
    logic [15:0] a, d;
    ops[0] = 8'h48; ops[1] = 8'h47; ops[2] = 8'h57;
    ops[3] = 8'h52; ops[4] = 8'h77; ops[5] = 8'h72;
    for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));

    #12;
    check_idle_outputs("reset");
    check("reset_addr", 32'(bus_addr), 32'd0);
    check("reset_wdata", 32'(bus_wdata), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios.
    run_cmd(8'h48, 16'h0000, 16'h0000);
    run_cmd(8'h57, 16'h0010, 16'hBEEF);
    tx_stall = 8;
    run_cmd(8'h52, 16'h0010, 16'h0000);
    run_cmd(8'h57, 16'hFFFF, 16'h0001);
    run_cmd(8'h77, 16'h0000, 16'h0002);
    run_cmd(8'h72, 16'h0000, 16'h0000);
    run_cmd(8'h47, 16'h0000, 16'h0000);
    run_cmd(8'h57, 16'h0020, 16'h1234);
    run_cmd(8'h52, 16'h0020, 16'h0000);

    // Reset in the middle of a 'W' command while released.
    send_byte(8'h57);
    send_byte(8'h00);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("midcmd_reset");
    @(negedge clk);
    rst = 1'b0;
    m_addr = 16'h0000;
    m_hold = 1'b1;
    $display("[TB] reset mid-command applied");
    run_cmd(8'h52, 16'h0010, 16'h0000);

    // Randomised command stream with random transmitter back-pressure.
    tx_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                      : 16'($urandom_range(0, 63));
      d = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        do op = 8'($urandom);
        while (op == 8'h48 || op == 8'h47 || op == 8'h57 ||
               op == 8'h52 || op == 8'h77 || op == 8'h72);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_cmd(op, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
